// File: rtl/control_unit_if.sv
// control_unit_if: instruction/halt inputs and every datapath strobe of the control unit.
interface control_unit_if;
  logic [31:0] IR;
  logic Stop, Run, illegal_op;
  logic [4:0] alu_op;
  logic PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout;
  logic MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin;
  logic Gra, Grb, Grc, IncPC, Read, Write;
  modport master (
    input  IR, Stop,
    output Run, illegal_op, alu_op, PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout,
           MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin,
           Gra, Grb, Grc, IncPC, Read, Write
  );
  modport slave (
    output IR, Stop,
    input  Run, illegal_op, alu_op, PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout,
           MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin,
           Gra, Grb, Grc, IncPC, Read, Write
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer; fetch T0-T2, opcode-specific execute T3-T7, registered strobes.
module control_unit (
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master cu
);
  localparam int OP_W = 5;
  localparam int IR_W = 32;
  localparam logic [OP_W-1:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD = 5'b00011, OP_AND = 5'b01001, OP_OR = 5'b01010;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_NEG = 5'b10001, OP_NOT = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP = 5'b11010, OP_HALT = 5'b11011;
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out, c_out, ba_out, r_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, zlo_in, zhi_in, hi_in, lo_in, r_in;
    logic gra, grb, grc, inc_pc, read, write, illegal_op, run;
    logic [OP_W-1:0] alu_op;
  } ctl_t;
  state_t state_q, state_d;
  logic [OP_W-1:0] op_q, op_d, op_in;
  ctl_t ctl_q, ctl_d;
  logic unused_ir;
  assign unused_ir = ^cu.IR[IR_W-OP_W-1:0];
  function automatic logic is_mem(logic [OP_W-1:0] op);
    return op == OP_LD || op == OP_LDI || op == OP_ST;
  endfunction
  function automatic logic is_rtype(logic [OP_W-1:0] op);
    return op >= OP_ADD && op <= 5'b01011;
  endfunction
  function automatic logic is_imm(logic [OP_W-1:0] op);
    return op >= 5'b01100 && op <= OP_ORI;
  endfunction
  function automatic logic is_muldiv(logic [OP_W-1:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
  function automatic logic is_unary(logic [OP_W-1:0] op);
    return op == OP_NEG || op == OP_NOT;
  endfunction
  // Undefined opcodes end in T3 so they retire like a one-step nop.
  function automatic state_t last_step(logic [OP_W-1:0] op);
    return (op == OP_LD || op == OP_ST) ? T7 :
           is_muldiv(op) ? T6 :
           (is_rtype(op) || is_imm(op) || op == OP_LDI) ? T5 :
           is_unary(op) ? T4 : T3;
  endfunction
  function automatic ctl_t decode(state_t s, logic [OP_W-1:0] op);
    ctl_t c;
    c = '0;
    c.run = s != RST && s != HALT;
    case (s)
      T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlo_in = 1'b1; end
      T1: begin c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      T3:
        if (is_unary(op)) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.alu_op = op; c.zlo_in = 1'b1;
        end else if (is_muldiv(op)) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else if (is_mem(op) || is_rtype(op) || is_imm(op)) begin
          c.grb = 1'b1; c.y_in = 1'b1; c.ba_out = is_mem(op); c.r_out = !is_mem(op);
        end else
          c.illegal_op = 1'b1;
      T4:
        if (is_unary(op)) begin
          c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else if (is_muldiv(op)) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.alu_op = op; c.zlo_in = 1'b1; c.zhi_in = 1'b1;
        end else if (is_rtype(op)) begin
          c.grc = 1'b1; c.r_out = 1'b1; c.alu_op = op; c.zlo_in = 1'b1;
        end else begin
          c.c_out = 1'b1; c.zlo_in = 1'b1;
          c.alu_op = op == OP_ANDI ? OP_AND : op == OP_ORI ? OP_OR : OP_ADD;
        end
      T5: begin
        c.zlo_out = 1'b1;
        if (is_muldiv(op)) c.lo_in = 1'b1;
        else if (op == OP_LD || op == OP_ST) c.mar_in = 1'b1;
        else begin c.gra = 1'b1; c.r_in = 1'b1; end
      end
      T6:
        if (is_muldiv(op)) begin
          c.zhi_out = 1'b1; c.hi_in = 1'b1;
        end else if (op == OP_LD) begin
          c.read = 1'b1; c.mdr_in = 1'b1;
        end else begin
          c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
        end
      T7:
        if (op == OP_LD) begin
          c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else
          c.write = 1'b1;
      default: ;
    endcase
    return c;
  endfunction
  always_comb begin
    op_in = cu.IR[IR_W-1 -: OP_W];
    op_d = op_q;
    state_d = state_q;
    case (state_q)
      RST: state_d = T0;
      T0: state_d = T1;
      T1: state_d = T2;
      T2: begin
        op_d = op_in;
        state_d = op_in == OP_HALT ? HALT : op_in == OP_NOP ? (cu.Stop ? HALT : T0) : T3;
      end
      HALT: state_d = HALT;
      default: state_d = state_q == last_step(op_q) ? (cu.Stop ? HALT : T0) : state_t'(state_q + 4'd1);
    endcase
    ctl_d = decode(state_d, op_d);
  end
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= RST;
      op_q <= '0;
      ctl_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      ctl_q <= ctl_d;
    end
  end
  assign {cu.PCout, cu.Zlowout, cu.ZHighout, cu.MDRout, cu.Cout, cu.BAout, cu.Rout,
          cu.MARin, cu.PCin, cu.MDRin, cu.IRin, cu.Yin, cu.ZLowIn, cu.ZHighIn, cu.HIin, cu.LOin, cu.Rin,
          cu.Gra, cu.Grb, cu.Grc, cu.IncPC, cu.Read, cu.Write, cu.illegal_op, cu.Run, cu.alu_op} = ctl_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random instruction streams checked against a per-opcode strobe-sequence model.
module tb_control_unit;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int passed = 0;
  int total = 0;
  control_unit_if cu();
  control_unit dut (.Clock(clk), .Clear(clear), .cu(cu));
  always #5 clk = ~clk;
  localparam logic [24:0] M_RUN = 25'd1 << 0, M_ILL = 25'd1 << 1, M_WR = 25'd1 << 2, M_RD = 25'd1 << 3;
  localparam logic [24:0] M_INC = 25'd1 << 4, M_GRC = 25'd1 << 5, M_GRB = 25'd1 << 6, M_GRA = 25'd1 << 7;
  localparam logic [24:0] M_RIN = 25'd1 << 8, M_LOIN = 25'd1 << 9, M_HIIN = 25'd1 << 10, M_ZHIN = 25'd1 << 11;
  localparam logic [24:0] M_ZLIN = 25'd1 << 12, M_YIN = 25'd1 << 13, M_IRIN = 25'd1 << 14, M_MDRIN = 25'd1 << 15;
  localparam logic [24:0] M_PCIN = 25'd1 << 16, M_MARIN = 25'd1 << 17, M_ROUT = 25'd1 << 18, M_BAOUT = 25'd1 << 19;
  localparam logic [24:0] M_COUT = 25'd1 << 20, M_MDROUT = 25'd1 << 21, M_ZHOUT = 25'd1 << 22, M_ZLOUT = 25'd1 << 23;
  localparam logic [24:0] M_PCOUT = 25'd1 << 24;
  typedef struct {logic [24:0] s; logic [4:0] alu;} step_t;
  step_t exp_q[$];
  function automatic logic [24:0] sample();
    return {cu.PCout, cu.Zlowout, cu.ZHighout, cu.MDRout, cu.Cout, cu.BAout, cu.Rout,
            cu.MARin, cu.PCin, cu.MDRin, cu.IRin, cu.Yin, cu.ZLowIn, cu.ZHighIn, cu.HIin, cu.LOin, cu.Rin,
            cu.Gra, cu.Grb, cu.Grc, cu.IncPC, cu.Read, cu.Write, cu.illegal_op, cu.Run};
  endfunction
  task automatic push(input logic [24:0] s, input logic [4:0] alu);
    step_t st;
    st.s = s | M_RUN;
    st.alu = alu;
    exp_q.push_back(st);
  endtask
  task automatic plan(input logic [4:0] op);
    exp_q.delete();
    push(M_PCOUT | M_MARIN | M_INC | M_ZLIN, 5'd0);
    push(M_ZLOUT | M_PCIN | M_RD | M_MDRIN, 5'd0);
    push(M_MDROUT | M_IRIN, 5'd0);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_GRC | M_ROUT | M_ZLIN, op);
      push(M_ZLOUT | M_GRA | M_RIN, 5'd0);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_COUT | M_ZLIN, op == 5'd12 ? 5'd3 : op == 5'd13 ? 5'd9 : 5'd10);
      push(M_ZLOUT | M_GRA | M_RIN, 5'd0);
    end else if (op == 5'd15 || op == 5'd16) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0);
      push(M_GRB | M_ROUT | M_ZLIN | M_ZHIN, op);
      push(M_ZLOUT | M_LOIN, 5'd0);
      push(M_ZHOUT | M_HIIN, 5'd0);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(M_GRB | M_ROUT | M_ZLIN, op);
      push(M_ZLOUT | M_GRA | M_RIN, 5'd0);
    end else if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZLIN, 5'd3);
      if (op == 5'd1) push(M_ZLOUT | M_GRA | M_RIN, 5'd0);
      else begin
        push(M_ZLOUT | M_MARIN, 5'd0);
        if (op == 5'd0) begin
          push(M_RD | M_MDRIN, 5'd0);
          push(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
          push(M_WR, 5'd0);
        end
      end
    end else if (op != 5'd26 && op != 5'd27)
      push(M_ILL, 5'd0);
  endtask
  // Entered and left at a negedge with the DUT in T0; stop_from holds Stop high from that step on.
  task automatic run_op(input logic [4:0] op, input int stop_from, input bit noise, input int clear_at, output bit halted);
    logic [24:0] o;
    bit stop_last;
    int n;
    plan(op);
    n = exp_q.size();
    cu.IR = {op, 27'($urandom)};
    stop_last = 1'b0;
    halted = 1'b0;
    for (int i = 0; i < n; i++) begin
      o = sample();
      total++;
      if (o !== exp_q[i].s || cu.alu_op !== exp_q[i].alu)
        $display("FAIL step op=%0d idx=%0d got=%h alu=%0d exp=%h alu=%0d", op, i, o, cu.alu_op, exp_q[i].s, exp_q[i].alu);
      else passed++;
      total++;
      if ($countones({cu.PCout, cu.Zlowout, cu.ZHighout, cu.MDRout, cu.Cout, cu.BAout, cu.Rout}) > 1 ||
          (cu.Read && cu.Write) || $countones({cu.Gra, cu.Grb, cu.Grc}) > 1)
        $display("FAIL invariant op=%0d idx=%0d got=%h exp=exclusive strobes", op, i, o);
      else passed++;
      if (i == clear_at) begin
        clear = 1'b1;
        cu.Stop = 1'b0;
        @(negedge clk);
        total++;
        if (sample() !== 25'd0 || cu.alu_op !== 5'd0) $display("FAIL clear_mid got=%h alu=%0d exp=0", sample(), cu.alu_op);
        else passed++;
        clear = 1'b0;
        @(negedge clk);
        return;
      end
      cu.Stop = (stop_from >= 0 && i >= stop_from) || (noise && $urandom_range(0, 3) == 0);
      if (i == n - 1 && noise) cu.Stop = $urandom_range(0, 7) == 0;
      if (i == n - 1) stop_last = cu.Stop;
      @(negedge clk);
    end
    cu.Stop = 1'b0;
    halted = stop_last || op == 5'd27;
    if (halted)
      for (int k = 0; k < 3; k++) begin
        total++;
        if (sample() !== 25'd0 || cu.alu_op !== 5'd0) $display("FAIL halt op=%0d cyc=%0d got=%h alu=%0d exp=0", op, k, sample(), cu.alu_op);
        else passed++;
        @(negedge clk);
      end
  endtask
  task automatic test_reset();
    clear = 1'b1;
    cu.Stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (sample() !== 25'd0 || cu.alu_op !== 5'd0) $display("FAIL reset cyc=%0d got=%h alu=%0d exp=0", k, sample(), cu.alu_op);
      else passed++;
    end
    clear = 1'b0;
    @(negedge clk);
    total++;
    if (sample() !== (M_PCOUT | M_MARIN | M_INC | M_ZLIN | M_RUN) || cu.alu_op !== 5'd0)
      $display("FAIL reset_t0 got=%h exp=%h", sample(), M_PCOUT | M_MARIN | M_INC | M_ZLIN | M_RUN);
    else passed++;
  endtask
  task automatic test_and();
    bit h;
    plan(5'b01001);
    total++;
    if (exp_q.size() != 6) $display("FAIL and_len got=%0d exp=6", exp_q.size());
    else passed++;
    run_op(5'b01001, -1, 1'b0, -1, h);
    cu.IR = 32'h4A920000;
    run_op(5'b01001, -1, 1'b0, -1, h);
  endtask
  task automatic test_ld_st();
    bit h;
    run_op(5'd0, -1, 1'b0, -1, h);
    run_op(5'd2, -1, 1'b0, -1, h);
    run_op(5'd1, -1, 1'b0, -1, h);
  endtask
  task automatic test_mul();
    bit h;
    run_op(5'd15, -1, 1'b0, -1, h);
    run_op(5'd16, -1, 1'b0, -1, h);
  endtask
  task automatic test_illegal();
    bit h;
    run_op(5'd31, -1, 1'b0, -1, h);
    run_op(5'd26, -1, 1'b0, -1, h);
  endtask
  task automatic test_stop();
    bit h;
    run_op(5'd3, 4, 1'b0, -1, h);
    test_reset();
  endtask
  task automatic test_clear_mid();
    bit h;
    run_op(5'd0, -1, 1'b0, 6, h);
  endtask
  task automatic test_random();
    bit h;
    logic [4:0] op;
    repeat (60) begin
      op = 5'($urandom_range(0, 31));
      run_op(op, -1, 1'b1, -1, h);
      if (h) test_reset();
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cu.IR = '0;
    cu.Stop = 1'b0;
    test_reset();
    test_and();
    test_ld_st();
    test_mul();
    test_illegal();
    test_stop();
    test_clear_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
